// File: rtl/bfly_stream_merge_pkg.sv
// Shared FFT stage constants and types: frame geometry, merge FSM states and
// the complex lane sample used by the butterfly, shift_reg and merge blocks.
package bfly_stream_merge_pkg;
  localparam int WIDTH = 10;
  localparam int NUM   = 16;
  localparam int DATA  = 512;
  localparam int COUNT = DATA / NUM;
  localparam int HALF  = COUNT / 2;
  localparam int CW    = $clog2(HALF) + 1;
  localparam int AW    = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} merge_state_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  typedef cplx_t [NUM-1:0] beat_t;
endpackage

// File: rtl/bfly_stream_merge_if.sv
// Butterfly-pair in / merged-stream out bundle between stage blocks.
interface bfly_stream_merge_if;
  import bfly_stream_merge_pkg::*;

  logic                       valid_in;
  logic [NUM-1:0][WIDTH-1:0]  din1_re, din1_im, din2_re, din2_im;
  logic [NUM-1:0][WIDTH-1:0]  dout_re, dout_im;
  logic                       valid_out, sop, eop, overflow;

  modport master (
    output valid_in, din1_re, din1_im, din2_re, din2_im,
    input  dout_re, dout_im, valid_out, sop, eop, overflow
  );
  modport slave (
    input  valid_in, din1_re, din1_im, din2_re, din2_im,
    output dout_re, dout_im, valid_out, sop, eop, overflow
  );
endinterface

// File: rtl/bfly_stream_merge_buf.sv
// HALF-deep x NUM-lane complex register file holding difference beats.
// Read is combinational; the parent registers the selected beat.
module bfly_stream_merge_buf
  import bfly_stream_merge_pkg::*;
(
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  beat_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output beat_t         o_rdata
);
  beat_t r_mem [HALF];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bfly_stream_merge.sv
// Re-serialises a butterfly sum/difference pair stream into one stream:
// sums pass with 1-cycle latency, differences are buffered then drained.
module bfly_stream_merge
  import bfly_stream_merge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  bfly_stream_merge_if.slave bus
);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(HALF - 1);

  merge_state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_wr_cnt, w_wr_nxt, r_rd_cnt, w_rd_nxt, w_wr_inc;
  beat_t         r_dout, w_dout_nxt, w_din1, w_din2, w_rdata;
  logic          r_valid, w_valid_nxt, r_sop, w_sop_nxt;
  logic          r_eop, w_eop_nxt, r_ovf, w_ovf_nxt, w_we;

  for (genvar g = 0; g < NUM; g++) begin : g_lane
    assign w_din1[g]       = {bus.din1_re[g], bus.din1_im[g]};
    assign w_din2[g]       = {bus.din2_re[g], bus.din2_im[g]};
    assign bus.dout_re[g]  = r_dout[g].re;
    assign bus.dout_im[g]  = r_dout[g].im;
  end

  assign bus.valid_out = r_valid;
  assign bus.sop       = r_sop;
  assign bus.eop       = r_eop;
  assign bus.overflow  = r_ovf;

  // wr_cnt is 0 in IDLE, so the same address serves the first write.
  bfly_stream_merge_buf u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_cnt[AW-1:0]),
    .i_wdata (w_din2),
    .i_raddr (r_rd_cnt[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign w_wr_inc = r_wr_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_cnt;
    w_rd_nxt    = r_rd_cnt;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_sop_nxt   = 1'b0;
    w_eop_nxt   = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_we        = 1'b0;
    case (r_state)
      IDLE: if (bus.valid_in) begin
        w_dout_nxt  = w_din1;
        w_valid_nxt = 1'b1;
        w_sop_nxt   = 1'b1;
        w_we        = 1'b1;
        w_wr_nxt    = w_wr_inc;
        w_rd_nxt    = '0;
        w_state_nxt = (w_wr_inc == HALF_C) ? DRAIN : PASS;
      end
      PASS: if (bus.valid_in) begin
        w_dout_nxt  = w_din1;
        w_valid_nxt = 1'b1;
        w_we        = 1'b1;
        w_wr_nxt    = w_wr_inc;
        if (w_wr_inc == HALF_C) begin
          w_state_nxt = DRAIN;
          w_rd_nxt    = '0;
        end
      end
      DRAIN: begin
        // Input here violates the butterfly gap guarantee: drop and flag.
        w_dout_nxt  = w_rdata;
        w_valid_nxt = 1'b1;
        w_rd_nxt    = r_rd_cnt + 1'b1;
        if (bus.valid_in) w_ovf_nxt = 1'b1;
        if (r_rd_cnt == LAST_C) begin
          w_eop_nxt   = 1'b1;
          w_state_nxt = IDLE;
          w_wr_nxt    = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_nxt;
      r_rd_cnt <= w_rd_nxt;
      r_dout   <= w_dout_nxt;
      r_valid  <= w_valid_nxt;
      r_sop    <= w_sop_nxt;
      r_eop    <= w_eop_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end
endmodule

// File: tb/tb_bfly_stream_merge.sv
// Bench for bfly_stream_merge: vector table, directed corner sequences and
// random frames against a queue-based stream model.
module tb_bfly_stream_merge;
  import bfly_stream_merge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bfly_stream_merge_if bus();
  bfly_stream_merge dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk = 0, n_pass = 0;
  int cnt_valid, cnt_sop, cnt_eop;
  logic saw77;

  // Reference: sums out as they arrive; once a frame's HALF pairs are in,
  // the queued differences come out one per cycle.
  beat_t m_dout;
  logic  m_valid, m_sop, m_eop, m_ovf;
  beat_t m_q[$];
  int    m_acc, m_drain;

  function automatic beat_t mk(input int re, input int im);
    beat_t b;
    for (int l = 0; l < NUM; l++) begin
      b[l].re = WIDTH'(re);
      b[l].im = WIDTH'(im);
    end
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    for (int l = 0; l < NUM; l++) begin
      b[l].re = WIDTH'($urandom);
      b[l].im = WIDTH'($urandom);
    end
    return b;
  endfunction

  function automatic beat_t dut_beat();
    beat_t b;
    for (int l = 0; l < NUM; l++) begin
      b[l].re = bus.dout_re[l];
      b[l].im = bus.dout_im[l];
    end
    return b;
  endfunction

  task automatic model_reset();
    m_dout = '0; m_valid = 0; m_sop = 0; m_eop = 0; m_ovf = 0;
    m_q.delete(); m_acc = 0; m_drain = 0;
  endtask

  task automatic model_step(input logic v, input beat_t d1, input beat_t d2);
    m_sop = 0; m_eop = 0;
    if (m_drain > 0) begin
      m_dout  = m_q.pop_front();
      m_valid = 1;
      m_eop   = (m_drain == 1);
      m_drain--;
      if (v) m_ovf = 1;
    end else if (v) begin
      m_dout  = d1;
      m_valid = 1;
      m_sop   = (m_acc == 0);
      m_q.push_back(d2);
      m_acc++;
      if (m_acc == HALF) begin m_drain = HALF; m_acc = 0; end
    end else m_valid = 0;
  endtask

  task automatic check(input string nm, input logic [3:0] af, input logic [3:0] ef,
                       input beat_t ad, input beat_t ed);
    n_chk++;
    if (af === ef && ad === ed) n_pass++;
    else $display("FAIL %s: v/sop/eop/ovf got %b want %b; dout got %h want %h",
                  nm, af, ef, ad, ed);
  endtask

  function automatic logic [3:0] dut_flags();
    return {bus.valid_out, bus.sop, bus.eop, bus.overflow};
  endfunction

  task automatic step(input logic v, input beat_t d1, input beat_t d2, input string nm);
    bus.valid_in = v;
    for (int l = 0; l < NUM; l++) begin
      bus.din1_re[l] = d1[l].re; bus.din1_im[l] = d1[l].im;
      bus.din2_re[l] = d2[l].re; bus.din2_im[l] = d2[l].im;
    end
    @(posedge clk);
    model_step(v, d1, d2);
    @(negedge clk);
    check(nm, dut_flags(), {m_valid, m_sop, m_eop, m_ovf}, dut_beat(), m_dout);
    if (bus.valid_out) cnt_valid++;
    if (bus.sop) cnt_sop++;
    if (bus.eop) cnt_eop++;
    for (int l = 0; l < NUM; l++)
      if (bus.valid_out && $signed(bus.dout_re[l]) == 77) saw77 = 1;
  endtask

  task automatic clr_cnt();
    cnt_valid = 0; cnt_sop = 0; cnt_eop = 0; saw77 = 0;
  endtask

  task automatic cnt_check(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  typedef struct {
    logic v;
    int   d1, d2;
    logic ev, es, ee;
    int   ere;
  } vec_t;
  vec_t tbl[40];

  initial begin
    // Single frame: 16 sums, then 100.. differences, then quiet with dout held.
    for (int i = 0; i < 40; i++) begin
      tbl[i].v   = (i < HALF);
      tbl[i].d1  = (i < HALF) ? i : 0;
      tbl[i].d2  = (i < HALF) ? 100 + i : 0;
      tbl[i].ev  = (i < COUNT);
      tbl[i].es  = (i == 0);
      tbl[i].ee  = (i == COUNT - 1);
      tbl[i].ere = (i < HALF) ? i : (i < COUNT) ? 100 + i - HALF : 100 + HALF - 1;
    end

    rst = 1'b1;
    bus.valid_in = 0;
    bus.din1_re = '0; bus.din1_im = '0; bus.din2_re = '0; bus.din2_im = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", dut_flags(), 4'b0000, dut_beat(), '0);
    rst = 1'b0;

    clr_cnt();
    for (int i = 0; i < 40; i++) begin
      step(tbl[i].v, mk(tbl[i].d1, -tbl[i].d1), mk(tbl[i].d2, -tbl[i].d2), "tbl_model");
      check("tbl_vec", dut_flags(), {tbl[i].ev, tbl[i].es, tbl[i].ee, 1'b0},
            dut_beat(), mk(tbl[i].ere, -tbl[i].ere));
    end

    // Back-to-back frames: the drain gap is exactly the next frame's start.
    clr_cnt();
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < COUNT; b++)
        step(b < HALF, mk(b, -b), mk(100 + b, -100 - b), "b2b");
    cnt_check("b2b_valid", cnt_valid, 2 * COUNT);
    cnt_check("b2b_sop", cnt_sop, 2);
    cnt_check("b2b_eop", cnt_eop, 2);
    cnt_check("b2b_ovf", int'(bus.overflow), 0);

    // Stall of 3 cycles after beat 5.
    clr_cnt();
    for (int b = 0; b < HALF + 3; b++) begin
      int k;
      k = (b < 6) ? b : b - 3;
      if (b >= 6 && b < 9) begin
        step(0, mk(55, 55), mk(66, 66), "stall_gap");
        cnt_check("stall_vout_low", int'(bus.valid_out), 0);
      end else step(1, mk(k, -k), mk(100 + k, -100 - k), "stall");
    end
    for (int b = 0; b < HALF; b++) begin
      step(0, '0, '0, "stall_drain");
      check("stall_drain_val", dut_flags(), {1'b1, 1'b0, b == HALF - 1, 1'b0},
            dut_beat(), mk(100 + b, -100 - b));
    end
    cnt_check("stall_valid", cnt_valid, COUNT);

    // Overflow: pair arriving on the 4th drain cycle is dropped.
    clr_cnt();
    for (int b = 0; b < HALF; b++) step(1, mk(b, -b), mk(100 + b, -100 - b), "ovf_pass");
    for (int b = 0; b < HALF; b++) begin
      step(b == 3, mk(77, 77), mk(77, 77), "ovf_drain");
      check("ovf_drain_val", dut_flags(), {1'b1, 1'b0, b == HALF - 1, b >= 3},
            dut_beat(), mk(100 + b, -100 - b));
    end
    repeat (3) step(0, '0, '0, "ovf_idle");
    cnt_check("ovf_sticky", int'(bus.overflow), 1);
    cnt_check("ovf_no77", int'(saw77), 0);

    // Asynchronous reset in the middle of PASS.
    for (int b = 0; b < 9; b++) step(1, mk(b + 1, -b - 1), mk(200, 200), "rst_pass");
    rst = 1'b1;
    #1;
    check("async_rst", dut_flags(), 4'b0000, dut_beat(), '0);
    model_reset();
    bus.valid_in = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    clr_cnt();
    for (int b = 0; b < COUNT + 2; b++) step(b < HALF, mk(b, -b), mk(100 + b, -100 - b), "post_rst");
    cnt_check("post_rst_valid", cnt_valid, COUNT);
    cnt_check("post_rst_sop", cnt_sop, 1);

    // Extremes with alternating sign per lane.
    begin
      beat_t e1, e2;
      for (int l = 0; l < NUM; l++) begin
        e1[l].re = (l % 2) ? -10'sd512 : 10'sd511;
        e1[l].im = (l % 2) ? 10'sd511 : -10'sd512;
        e2[l].re = e1[l].im;
        e2[l].im = e1[l].re;
      end
      for (int b = 0; b < COUNT; b++) begin
        step(b < HALF, e1, e2, "extreme");
        if (b == 0) check("extreme_sum", dut_flags(), 4'b1100, dut_beat(), e1);
        if (b == HALF) check("extreme_diff", dut_flags(), 4'b1000, dut_beat(), e2);
      end
    end

    // Random frames with random stalls and occasional illegal drain input.
    for (int f = 0; f < 8; f++) begin
      int acc;
      acc = 0;
      while (acc < HALF) begin
        logic v;
        v = ($urandom_range(3) != 0);
        step(v, rnd_beat(), rnd_beat(), "rand_pass");
        if (v) acc++;
      end
      for (int b = 0; b < HALF; b++)
        step($urandom_range(9) == 0, rnd_beat(), rnd_beat(), "rand_drain");
      repeat ($urandom_range(3)) step(0, rnd_beat(), rnd_beat(), "rand_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bfly_stream_merge.md
Name: bfly_stream_merge

Overview:
- Consumer of the radix-2 SDF butterfly stage output pair (do1 = sum, do2 = difference, 16 lanes).
- Re-serialises the pair into the single 16-lane stream that the next FFT stage expects.
  - Sum results are forwarded immediately.
  - Difference results are buffered for COUNT/2 beats, then drained directly behind the sums.
- Sits between butterfly and the next stage's delay line / twiddle multiplier; one instance per stage.

Parameters:
- WIDTH, 10, signed sample width of the butterfly outputs and of this block's outputs (no growth).
- NUM, 16, parallel lanes.
- DATA, 512, points per frame.
- COUNT, DATA/NUM, beats per frame at this stage.
- HALF, COUNT/2, pair beats per frame. Also the buffer depth.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  do1/do2 pair valid (butterfly valid_out).
- din1_re  in  WIDTH x [0:NUM-1]  sum, real.
- din1_im  in  WIDTH x [0:NUM-1]  sum, imag.
- din2_re  in  WIDTH x [0:NUM-1]  difference, real.
- din2_im  in  WIDTH x [0:NUM-1]  difference, imag.
- dout_re  out  WIDTH x [0:NUM-1]  merged stream, real.
- dout_im  out  WIDTH x [0:NUM-1]  merged stream, imag.
- valid_out  out  1  dout valid.
- sop  out  1  first beat of output frame.
- eop  out  1  last beat of output frame.
- overflow  out  1  sticky: valid_in seen while draining.

Behaviour:
- Reset (asynchronous, active-high; clk and rst only):
  - state=IDLE; wr_cnt=0, rd_cnt=0.
  - dout_re/dout_im all 0; valid_out=0, sop=0, eop=0, overflow=0.
  - Buffer contents are not reset; they are don't-care.
  - Reset mid-frame drops the frame; no partial output afterwards.
- All outputs are registered. Latency is 1 cycle: the do1 pair accepted on edge k appears on dout after edge k.
- Counters: wr_cnt and rd_cnt are $clog2(HALF)+1 bits and never exceed HALF.
- FSM IDLE -> PASS -> DRAIN -> IDLE:
  - IDLE:
    - On valid_in: drive dout<=din1, valid_out=1, sop=1.
    - Write din2 to buf[0]; wr_cnt<=1; go PASS.
    - If HALF==1, go DRAIN directly.
  - PASS:
    - valid_in=1: dout<=din1, valid_out=1; buf[wr_cnt]<=din2; wr_cnt++.
    - When this accept makes wr_cnt==HALF: go DRAIN, rd_cnt<=0.
    - valid_in=0 (gap mid-frame): valid_out=0, counters hold, dout holds its last value. A stall is legal.
  - DRAIN:
    - Each cycle: dout<=buf[rd_cnt], valid_out=1, rd_cnt++.
    - On rd_cnt==HALF-1: eop=1; go IDLE; wr_cnt<=0.
    - First drained beat directly follows the last do1 beat: no bubble.
    - Output frame is therefore exactly COUNT beats. It is contiguous whenever the input burst is contiguous.
- valid_in during DRAIN:
  - Illegal; the pair is dropped.
  - overflow<=1 and stays 1 until reset.
  - Drain continues unaffected.
- Butterfly timing guarantees a gap of HALF beats between bursts, equal to the drain length.
  - So valid_in arriving in the cycle right after eop is accepted by IDLE: back-to-back frames with no lost cycle.
- sop and eop are 1-cycle pulses qualified by valid_out. Both are 0 on every other cycle.
- Width rule: pure data movement, no arithmetic. Samples pass bit-exact.

Decomposition:
- Shared FFT package holds:
  - a merge-state enum (IDLE, PASS, DRAIN);
  - a complex-lane sample struct {re, im} of WIDTH;
  - constants NUM, DATA and derived COUNT and HALF.
  - These constants are shared with butterfly and shift_reg.
- One sub-module: merge_buf.
  - HALF-deep x NUM-lane complex register file.
  - Ports: write enable, write address, read address.
  - Read is combinational; the output register lives in the parent.

Test Plan:
- Single frame: lane l of beat b has din1_re=b, din2_re=100+b, im=-b, for 16 contiguous valid beats.
  - Required: 32 contiguous valid_out beats; dout_re = 0..15 then 100..115; im negated.
  - sop on beat 0, eop on beat 31.
- Back-to-back: two frames, each 16 valid then 16 idle.
  - Required: 64 contiguous valid_out beats; sop/eop at 0/31 and 32/63; overflow=0.
- Stall: valid_in low for 3 cycles after beat 5.
  - Required: valid_out low for exactly those 3 cycles.
  - Remaining beats are bit-exact; drain still outputs 100..115.
- Overflow: assert valid_in on the 4th drain cycle with din2_re=77.
  - Required: overflow=1 sticky; drain output unchanged (100..115); 77 never appears.
- Reset mid-PASS: assert rst after beat 8, then release.
  - Required: all outputs 0 immediately, asynchronously.
  - A new frame afterwards produces a clean 32-beat output with sop.
- Extremes: din values +511/-512.
  - Required: passed bit-exact with sign intact on every lane 0..15.
